// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg: baud-rate table and elaboration-time divisor helpers
// shared by uart_baud_gen and its fractional divider.
package uart_baud_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int NUM_RATES      = 8;

  function automatic longint baud_rate(input int sel);
    case (sel)
      0:       return 300;
      1:       return 1200;
      2:       return 4800;
      3:       return 9600;
      4:       return 19200;
      5:       return 38400;
      6:       return 57600;
      default: return 115200;
    endcase
  endfunction

  // Q carries FRAC_W fraction bits: D = Q >> FRAC_W, F = low FRAC_W bits.
  function automatic longint baud_q(input longint clk_hz, input int os,
                                    input int frac_w, input int sel);
    return (clk_hz << frac_w) / (baud_rate(sel) * os);
  endfunction

  function automatic longint baud_d(input longint clk_hz, input int os,
                                    input int frac_w, input int sel);
    return baud_q(clk_hz, os, frac_w, sel) >> frac_w;
  endfunction

  function automatic longint baud_f(input longint clk_hz, input int os,
                                    input int frac_w, input int sel);
    return baud_q(clk_hz, os, frac_w, sel) & ((longint'(1) << frac_w) - 1);
  endfunction
endpackage

// File: rtl/baud_frac_divider.sv
// baud_frac_divider: down-counting divisor that emits the registered sample
// strobe; the UART_BAUD_FRAC_EN build adds a fractional carry accumulator.
module baud_frac_divider #(
  parameter int DIV_W = 16,
`ifdef UART_BAUD_FRAC_EN
  parameter int FRAC_W = 4,
`endif
  parameter logic [DIV_W-1:0] RST_CNT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
`ifdef UART_BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] i_frac,
`endif
  output logic             o_tick_nxt,
  output logic             o_sample_tick
);
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_load_val;
  logic [DIV_W-1:0] w_reload;
  logic             r_sample_tick;

  assign o_tick_nxt    = i_run && (r_div_cnt == '0);
  assign o_sample_tick = r_sample_tick;
  assign w_load_val    = i_div - DIV_W'(1);

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W:0]   w_acc_sum;

  // A carry out of the accumulator stretches this period by one cycle.
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, i_frac};
  assign w_reload  = w_load_val + DIV_W'(w_acc_sum[FRAC_W]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_acc <= '0;
    else if (i_load)     r_acc <= '0;
    else if (o_tick_nxt) r_acc <= w_acc_sum[FRAC_W-1:0];
  end
`else
  assign w_reload = w_load_val;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt     <= RST_CNT;
      r_sample_tick <= 1'b0;
    end else begin
      r_sample_tick <= o_tick_nxt;
      if (i_load)          r_div_cnt <= w_load_val;
      else if (o_tick_nxt) r_div_cnt <= w_reload;
      else                 r_div_cnt <= r_div_cnt - DIV_W'(1);
    end
  end
endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample, mid-bit and bit-boundary strobes with glitch-free
// rate switching and resync. Define UART_BAUD_FRAC_EN for the fractional divider.
module uart_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       resync,
  input  logic [2:0] baud_select,
  output logic       sample_tick,
  output logic       mid_tick,
  output logic       bit_tick,
  output logic [2:0] active_sel
);
  localparam int               OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(baud_d(CLK_HZ, OVERSAMPLE, FRAC_W, 0) - 1);

  logic [DIV_W-1:0]  w_d_tab [NUM_RATES];
`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] w_f_tab [NUM_RATES];
`endif

  for (genvar g = 0; g < NUM_RATES; g++) begin : g_rate
    localparam longint D = baud_d(CLK_HZ, OVERSAMPLE, FRAC_W, g);
    assign w_d_tab[g] = DIV_W'(D);
`ifdef UART_BAUD_FRAC_EN
    assign w_f_tab[g] = FRAC_W'(baud_f(CLK_HZ, OVERSAMPLE, FRAC_W, g));
`endif
    if (D > (longint'(1) << DIV_W) - 1 || D < 2) begin : g_bad
      $error("uart_baud_gen: divisor %0d for rate code %0d out of range", D, g);
    end
  end

  logic [2:0]      r_pend_sel;
  logic [2:0]      r_active_sel;
  logic [OS_W-1:0] r_os_cnt;
  logic            r_mid_tick;
  logic            r_bit_tick;
  logic            w_hold;
  logic            w_tick_nxt;
  logic            w_bit_nxt;
  logic            w_sample_tick;
  logic [2:0]      w_sel_nxt;

  // Reloads always use the code that will be active after this edge, so a
  // new rate starts cleanly at a bit boundary, resync or while disabled.
  assign w_hold    = !enable || resync;
  assign w_bit_nxt = w_tick_nxt && (r_os_cnt == OS_LAST);
  assign w_sel_nxt = (w_hold || w_bit_nxt) ? r_pend_sel : r_active_sel;

  baud_frac_divider #(
    .DIV_W   (DIV_W),
`ifdef UART_BAUD_FRAC_EN
    .FRAC_W  (FRAC_W),
`endif
    .RST_CNT (RST_CNT)
  ) u_div (
    .clk           (clk),
    .reset         (reset),
    .i_run         (enable && !resync),
    .i_load        (w_hold),
    .i_div         (w_d_tab[w_sel_nxt]),
`ifdef UART_BAUD_FRAC_EN
    .i_frac        (w_f_tab[w_sel_nxt]),
`endif
    .o_tick_nxt    (w_tick_nxt),
    .o_sample_tick (w_sample_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_sel   <= '0;
      r_active_sel <= '0;
      r_os_cnt     <= '0;
      r_mid_tick   <= 1'b0;
      r_bit_tick   <= 1'b0;
    end else begin
      r_pend_sel   <= baud_select;
      r_active_sel <= w_sel_nxt;
      r_mid_tick   <= w_tick_nxt && (r_os_cnt == OS_MID);
      r_bit_tick   <= w_bit_nxt;
      if (w_hold || w_bit_nxt) r_os_cnt <= '0;
      else if (w_tick_nxt)     r_os_cnt <= r_os_cnt + OS_W'(1);
    end
  end

  assign sample_tick = w_sample_tick;
  assign mid_tick    = r_mid_tick;
  assign bit_tick    = r_bit_tick;
  assign active_sel  = r_active_sel;
endmodule
